// File: rtl/signed_bcd_converter_16_if.sv
`default_nettype none
// ============================================================================
// Module      : signed_bcd_converter_16_if
// Description : Handshake and data bundle between the calculator control
//               logic and the signed binary-to-BCD converter.
//               master : drives Start_in / Mag_in16 / Is_negative_in,
//                        observes the converter results.
//               slave  : the converter side.
//   Start_in       1  conversion request
//   Mag_in16      16  unsigned magnitude to convert
//   Is_negative_in 1  sign of the value (1 = negative)
//   Busy_out       1  conversion in progress
//   Done_out       1  one-cycle pulse, results valid
//   Bcd_out20     20  packed BCD, [19:16] ten-thousands ... [3:0] units
//   Sign_out       1  display sign (negative zero shows as positive)
//   Digit_en_out5  5  leading-zero blanking mask, bit i enables digit i
// Revision    : 1.0 - initial release
// ============================================================================
interface signed_bcd_converter_16_if;
    logic        Start_in;
    logic [15:0] Mag_in16;
    logic        Is_negative_in;
    logic        Busy_out;
    logic        Done_out;
    logic [19:0] Bcd_out20;
    logic        Sign_out;
    logic [4:0]  Digit_en_out5;

    modport master (
        output Start_in, Mag_in16, Is_negative_in,
        input  Busy_out, Done_out, Bcd_out20, Sign_out, Digit_en_out5
    );

    modport slave (
        input  Start_in, Mag_in16, Is_negative_in,
        output Busy_out, Done_out, Bcd_out20, Sign_out, Digit_en_out5
    );
endinterface
`default_nettype wire

// File: rtl/signed_bcd_converter_16.sv
`default_nettype none
// ============================================================================
// Module      : signed_bcd_converter_16
// Description : Sequential 16-bit binary to 5-digit BCD converter using one
//               shift-add-3 (double-dabble) iteration per clock. Produces a
//               display sign and a leading-zero mask alongside the digits.
//   Clk_in      1  system clock, rising edge
//   Reset_n_in  1  synchronous active-low reset
//   bus            slave side of signed_bcd_converter_16_if
//                  (start/busy/done handshake, operands, BCD results)
// Revision    : 1.0 - initial release
// ============================================================================
module signed_bcd_converter_16 (
    input  wire logic                  Clk_in,
    input  wire logic                  Reset_n_in,
    signed_bcd_converter_16_if.slave   bus
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_t;

    localparam logic [3:0] c_LAST_ITER = 4'd15;

    state_t      r_state,    w_state_nx;
    logic [15:0] r_shift,    w_shift_nx;
    logic [19:0] r_scratch,  w_scratch_nx;
    logic [3:0]  r_count,    w_count_nx;
    logic        r_sign_lat, w_sign_lat_nx;
    logic        r_mag_nz,   w_mag_nz_nx;
    logic [19:0] r_bcd,      w_bcd_nx;
    logic        r_sign,     w_sign_nx;
    logic [4:0]  r_digit_en, w_digit_en_nx;
    logic        r_done,     w_done_nx;

    logic [19:0] w_adj;          // scratch after the conditional +3
    logic [19:0] w_iter_scratch; // scratch after this iteration's shift
    logic [4:0]  w_digit_nz;     // per-digit nonzero flags of w_iter_scratch
    logic [4:0]  w_iter_en;

    // Add-3 correction per nibble; a valid digit <=9 never overflows 4 bits.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_digit
            always_comb begin
                w_adj[4*gi +: 4] = r_scratch[4*gi +: 4];
                if (r_scratch[4*gi +: 4] >= 4'd5)
                    w_adj[4*gi +: 4] = r_scratch[4*gi +: 4] + 4'd3;
            end
            assign w_digit_nz[gi] = |w_iter_scratch[4*gi +: 4];
        end
    endgenerate

    assign w_iter_scratch = {w_adj[18:0], r_shift[15]};

    // A digit is shown when it or any more significant digit is nonzero;
    // the units digit is always shown.
    assign w_iter_en = {w_digit_nz[4],
                        |w_digit_nz[4:3],
                        |w_digit_nz[4:2],
                        |w_digit_nz[4:1],
                        1'b1};

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_scratch_nx  = r_scratch;
        w_count_nx    = r_count;
        w_sign_lat_nx = r_sign_lat;
        w_mag_nz_nx   = r_mag_nz;
        w_bcd_nx      = r_bcd;
        w_sign_nx     = r_sign;
        w_digit_en_nx = r_digit_en;
        w_done_nx     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start_in) begin
                    w_state_nx    = S_CONVERT;
                    w_shift_nx    = bus.Mag_in16;
                    w_sign_lat_nx = bus.Is_negative_in;
                    w_mag_nz_nx   = |bus.Mag_in16;
                    w_scratch_nx  = 20'h00000;
                    w_count_nx    = 4'd0;
                end
            end
            S_CONVERT: begin
                w_scratch_nx = w_iter_scratch;
                w_shift_nx   = {r_shift[14:0], 1'b0};
                w_count_nx   = r_count + 4'd1;
                if (r_count == c_LAST_ITER) begin
                    w_bcd_nx      = w_iter_scratch;
                    // Negative zero is displayed without a minus sign.
                    w_sign_nx     = r_sign_lat & r_mag_nz;
                    w_digit_en_nx = w_iter_en;
                    w_done_nx     = 1'b1;
                    w_state_nx    = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_in) begin
        if (!Reset_n_in) begin
            r_state    <= S_IDLE;
            r_shift    <= 16'h0000;
            r_scratch  <= 20'h00000;
            r_count    <= 4'd0;
            r_sign_lat <= 1'b0;
            r_mag_nz   <= 1'b0;
            r_bcd      <= 20'h00000;
            r_sign     <= 1'b0;
            r_digit_en <= 5'b00001;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_scratch  <= w_scratch_nx;
            r_count    <= w_count_nx;
            r_sign_lat <= w_sign_lat_nx;
            r_mag_nz   <= w_mag_nz_nx;
            r_bcd      <= w_bcd_nx;
            r_sign     <= w_sign_nx;
            r_digit_en <= w_digit_en_nx;
            r_done     <= w_done_nx;
        end
    end

    assign bus.Busy_out      = (r_state == S_CONVERT);
    assign bus.Done_out      = r_done;
    assign bus.Bcd_out20     = r_bcd;
    assign bus.Sign_out      = r_sign;
    assign bus.Digit_en_out5 = r_digit_en;

endmodule
`default_nettype wire

// File: tb/tb_signed_bcd_converter_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_bcd_converter_16
// Description : Directed self-checking bench for signed_bcd_converter_16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_bcd_converter_16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    signed_bcd_converter_16_if bus ();

    signed_bcd_converter_16 u_dut (
        .Clk_in     (clk),
        .Reset_n_in (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(bus.Busy_out), 32'd0);
        check({tag, "_done"}, 32'(bus.Done_out), 32'd0);
        check({tag, "_bcd"},  32'(bus.Bcd_out20), 32'h00000);
        check({tag, "_sign"}, 32'(bus.Sign_out), 32'd0);
        check({tag, "_en"},   32'(bus.Digit_en_out5), 32'b00001);
    endtask

    // Accepts one conversion and waits for Done_out, checking latency,
    // result values, held outputs during CONVERT and the one-cycle pulse.
    task automatic run_conv(input string tag, input logic [15:0] mag, input logic neg,
                            input logic [19:0] exp_bcd, input logic exp_sign,
                            input logic [4:0] exp_en);
        int          cycles;
        bit          seen;
        logic [19:0] held_bcd;
        held_bcd = bus.Bcd_out20;
        @(negedge clk);
        bus.Mag_in16       = mag;
        bus.Is_negative_in = neg;
        bus.Start_in       = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_after_accept"}, 32'(bus.Busy_out), 32'd1);
        @(negedge clk);
        bus.Start_in       = 1'b0;
        bus.Mag_in16       = ~mag;
        bus.Is_negative_in = ~neg;
        cycles = 0;
        seen   = 1'b0;
        while (cycles < 40 && !seen) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.Done_out) seen = 1'b1;
            if (cycles == 8)
                check({tag, "_held_bcd"}, 32'(bus.Bcd_out20), 32'(held_bcd));
        end
        check({tag, "_latency"}, 32'(cycles), 32'd16);
        check({tag, "_busy_at_done"}, 32'(bus.Busy_out), 32'd0);
        check({tag, "_bcd"},  32'(bus.Bcd_out20), 32'(exp_bcd));
        check({tag, "_sign"}, 32'(bus.Sign_out), 32'(exp_sign));
        check({tag, "_en"},   32'(bus.Digit_en_out5), 32'(exp_en));
        @(posedge clk); #1;
        check({tag, "_done_width"}, 32'(bus.Done_out), 32'd0);
        check({tag, "_bcd_hold"},   32'(bus.Bcd_out20), 32'(exp_bcd));
    endtask

    initial begin
        int dones;
        n_tests            = 0;
        n_fail             = 0;
        rst_n              = 1'b0;
        bus.Start_in       = 1'b0;
        bus.Mag_in16       = 16'h0000;
        bus.Is_negative_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("idle");

        run_conv("c12345", 16'd12345, 1'b0, 20'h12345, 1'b0, 5'b11111);
        run_conv("c65535", 16'd65535, 1'b1, 20'h65535, 1'b1, 5'b11111);
        run_conv("negzero", 16'd0,    1'b1, 20'h00000, 1'b0, 5'b00001);
        run_conv("c7",      16'd7,    1'b1, 20'h00007, 1'b1, 5'b00001);

        // Start ignored during CONVERT; operand change after accept ignored.
        @(negedge clk);
        bus.Mag_in16       = 16'd1000;
        bus.Is_negative_in = 1'b0;
        bus.Start_in       = 1'b1;
        @(posedge clk); #1;
        dones = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 5) begin
                bus.Mag_in16 = 16'd9999;
                bus.Start_in = 1'b1;
            end else begin
                bus.Start_in = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.Done_out) dones++;
            check("done_busy_overlap", 32'(bus.Done_out & bus.Busy_out), 32'd0);
        end
        check("ignore_start_dones", 32'(dones), 32'd1);
        check("ignore_start_bcd",   32'(bus.Bcd_out20), 32'h01000);
        check("ignore_start_en",    32'(bus.Digit_en_out5), 32'b01111);
        check("ignore_start_sign",  32'(bus.Sign_out), 32'd0);

        // Reset aborts a conversion in progress without a Done_out.
        @(negedge clk);
        bus.Mag_in16       = 16'd4321;
        bus.Is_negative_in = 1'b1;
        bus.Start_in       = 1'b1;
        @(posedge clk); #1;
        dones = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.Start_in = 1'b0;
            rst_n        = (c == 8) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (bus.Done_out) dones++;
            if (c == 8) check_reset_values("abort");
        end
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_dones", 32'(dones), 32'd0);
        check_reset_values("abort_after");

        run_conv("c250", 16'd250, 1'b0, 20'h00250, 1'b0, 5'b00111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
